// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of an async square wave in clk cycles.
// Optional duty measurement is built when CLK_METER_DUTY_EN is defined; otherwise high_time is 0.
module clk_period_meter #(
    parameter int          CNT_W       = 16,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 2**CNT_W-1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             locked,
    output logic             timeout
);
    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);
    typedef enum logic [1:0] {S_WAIT, S_RUN, S_TMO} state_t;
    state_t state, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic s, s_d, rise, publish;
    logic [CNT_W-1:0] cnt;
    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    // synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_WAIT;
        else     state <= nxt;
    end
    // next state: a rise always wins over the timeout check
    always_comb begin
        nxt = (state == S_RUN) ? ((!rise && cnt == TMAX) ? S_TMO : S_RUN)
                               : (rise ? S_RUN : state);
    end
    // outputs decoded from state; only a rise seen in RUN closes a valid interval
    always_comb begin
        timeout = (state == S_TMO);
        publish = (state == S_RUN) && rise;
    end
    // period counter saturates at TIMEOUT, which also freezes it in TMO
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              cnt <= '0;
        else if (rise)                        cnt <= CNT_W'(1);
        else if (state == S_RUN && cnt != TMAX) cnt <= cnt + 1'b1;
    end
`ifdef CLK_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt;
    // high-time counter advances only alongside cnt, so it can never pass it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    hcnt <= '0;
        else if (rise)                              hcnt <= CNT_W'(1);
        else if (s && state == S_RUN && cnt != TMAX) hcnt <= hcnt + 1'b1;
    end
    // high time published together with period
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          high_time <= '0;
        else if (publish) high_time <= hcnt;
    end
`else
    assign high_time = '0;
`endif
    // publish registers; locked compares against the previously published period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period <= '0;
            valid  <= 1'b0;
            locked <= 1'b0;
        end else begin
            valid <= publish;
            if (publish) begin
                period <= cnt;
                locked <= (cnt == period);
            end else if (nxt == S_TMO) begin
                locked <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed self-checking bench for clk_period_meter with TIMEOUT=20.
module tb_clk_period_meter;
    localparam int CNT_W = 16;
    localparam int TMO = 20;
`ifdef CLK_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1, sig_in;
    logic [CNT_W-1:0] period, high_time;
    logic valid, locked, timeout;
    int total = 0, bad = 0;
    int hi = 2, lo = 2;
    bit en = 1'b0;

    clk_period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .period(period), .high_time(high_time),
        .valid(valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // wave generator; hi/lo are read at the start of each phase
    initial begin
        sig_in = 1'b0;
        forever begin
            if (en) begin
                repeat (hi) begin sig_in = 1'b1; @(negedge clk); end
                repeat (lo) begin sig_in = 1'b0; @(negedge clk); end
            end else begin
                sig_in = 1'b0;
                @(negedge clk);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wv(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            got = valid;
        end
        chk({tag, "_valid_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int k;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", 32'(period), 0);
        chk("rst_high", 32'(high_time), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(negedge clk); rst = 1'b0; en = 1'b1;
        // divide-by-4
        wv("d4a");
        chk("d4a_period", 32'(period), 4);
        chk("d4a_high", 32'(high_time), DUTY ? 2 : 0);
        chk("d4a_locked", 32'(locked), 0);
        wv("d4b");
        chk("d4b_period", 32'(period), 4);
        chk("d4b_locked", 32'(locked), 1);
        repeat (3) begin @(posedge clk); #1; end
        chk("d4_gap", 32'(valid), 0);
        @(posedge clk); #1;
        chk("d4_every4", 32'(valid), 1);
        // duty change: period 10, 3 high
        hi = 3; lo = 7;
        wv("dc1"); wv("dc2"); wv("dc3");
        chk("dc_period", 32'(period), 10);
        chk("dc_high", 32'(high_time), DUTY ? 3 : 0);
        wv("dc4");
        chk("dc_locked", 32'(locked), 1);
        chk("dc_period2", 32'(period), 10);
        // period step 10 -> 6; any interval straddling the change is also 6
        lo = 3;
        k = 0;
        do begin wv("ps"); k++; end while (period == 10 && k < 4);
        chk("ps_period", 32'(period), 6);
        chk("ps_locked0", 32'(locked), 0);
        wv("ps2");
        chk("ps2_period", 32'(period), 6);
        chk("ps2_locked", 32'(locked), 1);
        // back to clk/4, then stop the wave
        hi = 2; lo = 2;
        repeat (4) wv("tl");
        chk("tl_locked", 32'(locked), 1);
        en = 1'b0;
        k = 0;
        for (int i = 0; i < 80 && !timeout; i++) begin
            @(posedge clk); #1;
            k = valid ? 0 : k + 1;
        end
        chk("tmo_asserted", 32'(timeout), 1);
        chk("tmo_delay", 32'(k), TMO);
        chk("tmo_locked", 32'(locked), 0);
        chk("tmo_period_held", 32'(period), 4);
        // restart: first rise clears timeout without valid
        en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40 && timeout; i++) begin
            @(posedge clk); #1;
            seen |= valid;
        end
        chk("tmo_cleared", 32'(timeout), 0);
        chk("tmo_no_valid", 32'(seen), 0);
        wv("tr");
        chk("tr_period", 32'(period), 4);
        chk("tr_timeout", 32'(timeout), 0);
        // reset mid-period while locked
        wv("rl");
        chk("rl_locked", 32'(locked), 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("mr_period", 32'(period), 0);
        chk("mr_high", 32'(high_time), 0);
        chk("mr_valid", 32'(valid), 0);
        chk("mr_locked", 32'(locked), 0);
        chk("mr_timeout", 32'(timeout), 0);
        @(negedge clk); rst = 1'b0;
        wv("ar");
        chk("ar_period", 32'(period), 4);
        chk("ar_locked", 32'(locked), 0);
        // period of exactly TIMEOUT: rise coincides with cnt==TIMEOUT
        hi = 10; lo = 10;
        repeat (3) wv("ec");
        chk("ec_period", 32'(period), TMO);
        chk("ec_timeout", 32'(timeout), 0);
        seen = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            seen |= timeout;
        end
        chk("ec_never_tmo", 32'(seen), 0);
        chk("ec_period2", 32'(period), TMO);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_period_meter.md
# clk_period_meter

Measures an incoming square wave in system-clock cycles, such as a divided clock or an external pixel or sync strobe. The block is the receiving end of the clock-divider path: a divider generates the wave, and this block recovers its period and high time. Outputs are used for bring-up checks and lock indication on the VGA clocking path. It is fully synchronous to `clk`, and `sig_in` is treated as asynchronous.

## Interface
- `CNT_W`, 16: width of the period and high-time counters and outputs.
- `SYNC_STAGES`, 2: number of synchroniser flops on `sig_in`. Legal values are 2 or more.
- `TIMEOUT`, 2**CNT_W-1: number of cycles without a rising edge before `timeout` asserts. Legal range is 2..2**CNT_W-1.

- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous reset, active-high.
- `sig_in`, input, 1: wave to measure, asynchronous to `clk`.
- `period`, output, CNT_W: clk cycles between the last two rising edges.
- `high_time`, output, CNT_W: clk cycles `sig_in` was sampled high within the last period.
- `valid`, output, 1: one-cycle pulse when `period` and `high_time` update.
- `locked`, output, 1: the last two published periods are equal.
- `timeout`, output, 1: level; no rising edge seen for `TIMEOUT` cycles.

## Operation
- **Synchroniser and edge detect:**
  - `sig_in` passes through `SYNC_STAGES` flops to produce `s`, and `s_d` is `s` delayed by one cycle.
  - `rise = s & ~s_d`.
- **Counters:**
  - `cnt` increments by 1 each cycle in RUN and is loaded with 1 on `rise`.
  - `hcnt` increments by 1 when `s` = 1 and is loaded with 1 on `rise`.
  - Neither counter wraps: `TIMEOUT` caps `cnt`, and `hcnt` never exceeds `cnt`.
- **FSM states:**
  - **WAIT:** reset state, waiting for the first edge. On `rise`, go to RUN and load the counters. Nothing is published.
  - **RUN:**
    - On `rise`: `period <= cnt`, `high_time <= hcnt`, pulse `valid`, reload the counters.
    - Else if `cnt == TIMEOUT`: go to TMO.
  - **TMO:**
    - `timeout` = 1, `locked` <= 0, counters hold.
    - On `rise`: go to RUN, reload the counters, clear `timeout`. No `valid`, because the interval is invalid.
- **locked:**
  - On each `valid`, `locked` <= (new `period` == previous `period`).
  - Cleared on entry to TMO and on reset.
- **Boundary rules:**
  - If `rise` occurs in the same cycle that `cnt` reaches `TIMEOUT`, `rise` wins: `period` = `TIMEOUT` is published and the FSM stays in RUN.
  - The first edge after reset or after TMO is never published. Two edges are required.
  - A constant-high or constant-low `sig_in` ends in TMO.
  - `high_time` equal to `period` is legal: the wave was high for the whole interval as sampled.
- **Reset mid-operation:** the FSM goes to WAIT and all outputs return to their reset values immediately, regardless of state.

## Timing
- Reset values: `period` = 0, `high_time` = 0, `valid` = 0, `locked` = 0, `timeout` = 0. The FSM is in WAIT and the synchroniser flops are 0.
- Latency from a `sig_in` rising edge to `rise` is `SYNC_STAGES`+1 clk edges, ±1 for asynchronous sampling.
- `valid` and the updated `period`/`high_time` appear in the cycle after `rise`. `locked` updates in the same cycle as `valid`.
- `period` and `high_time` hold their value between `valid` pulses, including while in TMO.
- `timeout` asserts in the cycle after `cnt` reaches `TIMEOUT` with no `rise`, which is `TIMEOUT` cycles after the last `rise`.
- `timeout` deasserts in the cycle after the next `rise`.
- The minimum measurable period is 2 cycles. Input faster than clk/2 aliases and is not specified.

## Configuration
- `CLK_METER_DUTY_EN`:
  - Defined: `hcnt` and the `high_time` register are built as described above.
  - Undefined: `hcnt` is removed and `high_time` is tied to 0. All other behaviour is identical.

## Test plan
- **Divide-by-4 input:** drive `sig_in` high 2 cycles, low 2 cycles (clk/4, 50% duty), synchronous to `clk`. Required response:
  - First `valid` comes 2 edges after reset release: `period` = 4, `high_time` = 2 (with `CLK_METER_DUTY_EN`), `locked` = 0.
  - Next `valid`: `locked` = 1.
  - `valid` pulses every 4 cycles thereafter.
- **Duty change:** drive a period of 10 cycles with 3 high. Required: `period` = 10, `high_time` = 3, `locked` = 1 from the second `valid`.
- **Period step:** switch from period 10 to 6. Required:
  - First `valid` after the change: `period` = 6, `locked` = 0.
  - Following `valid`: `locked` = 1.
- **Timeout:** with `TIMEOUT` = 20, hold `sig_in` low after a lock. Required:
  - `timeout` = 1 exactly 20 cycles after the last `rise`, with `locked` = 0 and `period` held.
  - Restart the clk/4 wave: the first `rise` clears `timeout` without `valid`; the second `rise` gives `valid` with `period` = 4.
- **Reset and edge collision:**
  - Assert `rst` mid-period while locked. Required: all outputs are 0 within the same cycle, and two edges are needed before the next `valid`.
  - Separately, align a `rise` with `cnt` = `TIMEOUT`. Required: `valid` with `period` = `TIMEOUT` and `timeout` stays 0.
